// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared types and constants for the RV32M issue controller and its sign-fix stage.
package muldiv_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdop_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4,
    S_DRAIN = 3'd5
  } mdstate_e;

  typedef enum logic [2:0] {
    alu_nop   = 3'd0,
    alu_mul_s = 3'd1,
    alu_mul_u = 3'd2,
    alu_div_s = 3'd3,
    alu_div_u = 3'd4,
    alu_rem_s = 3'd5,
    alu_rem_u = 3'd6
  } aluop_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic aluop_e alu_op_for(input mdop_e op);
    case (op)
      OP_MUL, OP_MULH:     return alu_mul_s;
      OP_MULHSU, OP_MULHU: return alu_mul_u;
      OP_DIV:              return alu_div_s;
      OP_DIVU:             return alu_div_u;
      OP_REM:              return alu_rem_s;
      OP_REMU:             return alu_rem_u;
      default:             return alu_nop;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the raw 64-bit ALU result into the RV32M architectural 32-bit result.
module muldiv_sign_fix
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]          op_i,
  input  logic                s1_i,
  input  logic                s2_i,
  input  logic [2*XLEN-1:0]   raw_i,
  output logic [XLEN-1:0]     res_o
);

  logic [2*XLEN-1:0] neg_raw;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   neg_lo;

  assign neg_raw = {(2*XLEN){1'b0}} - raw_i;
  assign lo      = raw_i[XLEN-1:0];
  assign neg_lo  = {XLEN{1'b0}} - lo;

  // Signed divide/remainder arrive as magnitudes; MULHSU arrives as |rs1|*rs2.
  always_comb begin
    res_o = lo;
    case (mdop_e'(op_i))
      OP_MUL:             res_o = lo;
      OP_MULH, OP_MULHU:  res_o = raw_i[2*XLEN-1:XLEN];
      OP_MULHSU:          res_o = s1_i ? neg_raw[2*XLEN-1:XLEN] : raw_i[2*XLEN-1:XLEN];
      OP_DIV:             res_o = (s1_i ^ s2_i) ? neg_lo : lo;
      OP_REM:             res_o = s1_i ? neg_lo : lo;
      OP_DIVU, OP_REMU:   res_o = lo;
      default:            res_o = lo;
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// RV32M initiator for the multi-cycle ALU: issue, wait, sign-fix and respond.
// Optional watchdog on the WAIT state is enabled with MULDIV_WATCHDOG_EN.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
`ifdef MULDIV_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 80
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [2:0]          req_op_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic                flush_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [XLEN-1:0]     rsp_data_o,
  output logic                rsp_err_o,
  output logic                stall_o,
  output logic [XLEN-1:0]     ALU_data1_o,
  output logic [XLEN-1:0]     ALU_data2_o,
  output logic [2:0]          ALU_op_o,
  input  logic [2*XLEN-1:0]   ALU_result_i,
  input  logic                ALU_busy_i
);

  mdstate_e          state_q, state_d;
  mdop_e             op_q, op_d;
  mdop_e             req_op;
  aluop_e            alu_op_q, alu_op_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [XLEN-1:0]   data1_q, data1_d, data2_q, data2_d;
  logic [2*XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d, fix_res;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              rs2_zero, div_ovf;
`ifdef MULDIV_WATCHDOG_EN
  logic [6:0]        wd_cnt_q, wd_cnt_d;
  logic              to_q, to_d;
`endif

  assign req_op   = mdop_e'(req_op_i);
  assign rs2_zero = (rs2_i == {XLEN{1'b0}});
  assign div_ovf  = (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);

  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
    .op_i  (op_q),
    .s1_i  (s1_q),
    .s2_i  (s2_q),
    .raw_i (res_q),
    .res_o (fix_res)
  );

  // Next-state and datapath capture; flush overrides every other transition.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    res_d      = res_q;
    rsp_data_d = rsp_data_q;
`ifdef MULDIV_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    to_d       = to_q;
`endif
    if (flush_i) begin
      if ((state_q == S_ISSUE || state_q == S_WAIT || state_q == S_DRAIN) && ALU_busy_i) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_IDLE;
      end
`ifdef MULDIV_WATCHDOG_EN
      to_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            op_d = req_op;
            s1_d = rs1_i[XLEN-1];
            s2_d = rs2_i[XLEN-1];
            if (rs2_zero && (req_op == OP_DIV || req_op == OP_DIVU)) begin
              rsp_data_d = ALL_ONES;
              state_d    = S_RESP;
            end else if (rs2_zero && (req_op == OP_REM || req_op == OP_REMU)) begin
              rsp_data_d = rs1_i;
              state_d    = S_RESP;
            end else if (div_ovf && req_op == OP_DIV) begin
              rsp_data_d = INT_MIN;
              state_d    = S_RESP;
            end else if (div_ovf && req_op == OP_REM) begin
              rsp_data_d = {XLEN{1'b0}};
              state_d    = S_RESP;
            end else begin
              data1_d = (req_op == OP_MULHSU) ? abs32(rs1_i) : rs1_i;
              data2_d = rs2_i;
              state_d = S_ISSUE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!op_q[2]) begin
            res_d   = ALU_result_i;
            state_d = S_FIX;
          end else begin
            state_d = S_WAIT;
`ifdef MULDIV_WATCHDOG_EN
            wd_cnt_d = 7'd0;
`endif
          end
        end
        S_WAIT: begin
          if (!ALU_busy_i) begin
            res_d   = ALU_result_i;
            state_d = S_FIX;
          end
`ifdef MULDIV_WATCHDOG_EN
          else if (wd_cnt_q == 7'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_DRAIN;
            to_d    = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 7'd1;
          end
`else
          else begin
            state_d = S_WAIT;
          end
`endif
        end
        S_FIX: begin
          rsp_data_d = fix_res;
          state_d    = S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_d = S_IDLE;
`ifdef MULDIV_WATCHDOG_EN
            to_d    = 1'b0;
`endif
          end else begin
            state_d = S_RESP;
          end
        end
        S_DRAIN: begin
          if (!ALU_busy_i) begin
`ifdef MULDIV_WATCHDOG_EN
            if (to_q) begin
              rsp_data_d = {XLEN{1'b0}};
              state_d    = S_RESP;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // The ALU only sees a real op while we are in ISSUE/WAIT; FIX forces nop.
    alu_op_d    = (state_d == S_ISSUE || state_d == S_WAIT) ? alu_op_for(op_d) : alu_nop;
    rsp_valid_d = (state_d == S_RESP);
`ifdef MULDIV_WATCHDOG_EN
    rsp_err_d   = (state_d == S_RESP) && to_d;
`else
    rsp_err_d   = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      data1_q     <= {XLEN{1'b0}};
      data2_q     <= {XLEN{1'b0}};
      alu_op_q    <= alu_nop;
      res_q       <= {(2*XLEN){1'b0}};
      rsp_data_q  <= {XLEN{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef MULDIV_WATCHDOG_EN
      wd_cnt_q    <= 7'd0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      alu_op_q    <= alu_op_d;
      res_q       <= res_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MULDIV_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      to_q        <= to_d;
`endif
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && !flush_i;
  assign stall_o     = (state_q != S_IDLE) || req_valid_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign ALU_data1_o = data1_q;
  assign ALU_data2_o = data2_q;
  assign ALU_op_o    = alu_op_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl with a behavioural multi-cycle ALU.
module tb_muldiv_issue_ctrl;

  localparam int DIVN = 34;
  localparam int DLAT = DIVN + 3;

  logic        clk, rst;
  logic        req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err, stall;
  logic [2:0]  req_op, alu_op;
  logic [31:0] rs1, rs2, rsp_data, d1, d2;
  logic [63:0] alu_res;
  logic        alu_busy;

  int tests_run = 0;
  int tests_failed = 0;
  int nonnop_cnt = 0;
  logic [31:0] exp_q[$];

  muldiv_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .stall_o(stall),
    .ALU_data1_o(d1), .ALU_data2_o(d2), .ALU_op_o(alu_op),
    .ALU_result_i(alu_res), .ALU_busy_i(alu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: combinational multiplier, DIVN-cycle divider returning magnitudes.
  logic        dv_run, dv_done, is_div, force_busy;
  int          dv_cnt;
  logic [63:0] dv_res;

  function automatic logic [63:0] model_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub;
    logic signed_op;
    signed_op = (op == 3'd3) || (op == 3'd5);
    ua = (signed_op && a[31]) ? (32'd0 - a) : a;
    ub = (signed_op && b[31]) ? (32'd0 - b) : b;
    if (ub == 32'd0) return 64'd0;
    if (op == 3'd3 || op == 3'd4) return {32'd0, ua / ub};
    return {32'd0, ua % ub};
  endfunction

  assign is_div   = (alu_op >= 3'd3) && (alu_op <= 3'd6);
  assign alu_busy = force_busy | dv_run | (is_div & ~dv_done & ~dv_run);

  always_comb begin
    logic signed [63:0] sa, sb;
    sa = {{32{d1[31]}}, d1};
    sb = {{32{d2[31]}}, d2};
    if (alu_op == 3'd1)      alu_res = sa * sb;
    else if (alu_op == 3'd2) alu_res = {32'd0, d1} * {32'd0, d2};
    else                     alu_res = dv_res;
  end

  always @(posedge clk) begin
    if (rst) begin
      dv_run <= 1'b0; dv_done <= 1'b0; dv_cnt <= 0; dv_res <= 64'd0;
    end else if (!dv_run && !dv_done && is_div) begin
      dv_run <= 1'b1; dv_cnt <= 1; dv_res <= model_div(alu_op, d1, d2);
    end else if (dv_run) begin
      if (dv_cnt == DIVN - 1) begin dv_run <= 1'b0; dv_done <= 1'b1; end
      else dv_cnt <= dv_cnt + 1;
    end else if (dv_done && alu_op == 3'd0) begin
      dv_done <= 1'b0;
    end
  end

  always @(posedge clk) if (alu_op != 3'd0) nonnop_cnt <= nonnop_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic [2:0]  aop;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input int idx);
    int lat, snap;
    logic got;
    logic [2:0] issue_op, prev_op;
    logic [31:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; rs1 = v.a; rs2 = v.b;
    #1;
    check($sformatf("v%0d_ready", idx), req_ready, 1);
    check($sformatf("v%0d_stall_idle", idx), stall, 1);
    snap = nonnop_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(v.exp);
    lat = 0; got = 1'b0; issue_op = 3'd7; prev_op = 3'd7;
    while (lat < 300 && !got) begin
      @(negedge clk);
      lat++;
      if (lat == 1) issue_op = alu_op;
      if (rsp_valid) got = 1'b1;
      else prev_op = alu_op;
    end
    if (!got) begin
      check($sformatf("v%0d_timeout", idx), 0, 1);
    end else begin
      if (exp_q.size() == 0) check("sb_empty", 0, 1);
      else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_data", idx), rsp_data, e);
      end
      check($sformatf("v%0d_latency", idx), lat, v.lat);
      check($sformatf("v%0d_issue_op", idx), issue_op, v.aop);
      check($sformatf("v%0d_err", idx), rsp_err, 0);
      if (v.lat > 1) check($sformatf("v%0d_fix_op_nop", idx), prev_op, 0);
      else check($sformatf("v%0d_no_alu_op", idx), nonnop_cnt - snap, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, bad;
    logic seen;
    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         3,    3'd1};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  3,    3'd2};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  3,    3'd1};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  3,    3'd2};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  3,    3'd1};
    vecs[5]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3,    3'd2};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DLAT, 3'd3};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DLAT, 3'd5};
    vecs[8]  = '{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  DLAT, 3'd3};
    vecs[9]  = '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          DLAT, 3'd5};
    vecs[10] = '{3'd5, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1,    3'd0};
    vecs[11] = '{3'd7, 32'h1234,       32'd0,          32'h1234,       1,    3'd0};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,    3'd0};
    vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,    3'd0};
    vecs[14] = '{3'd5, 32'd100,        32'd7,          32'd14,         DLAT, 3'd4};
    vecs[15] = '{3'd7, 32'd100,        32'd7,          32'd2,          DLAT, 3'd6};
    vecs[16] = '{3'd6, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,    3'd0};
    vecs[17] = '{3'd3, 32'd2,          32'd3,          32'd0,          3,    3'd2};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    flush = 1'b0; rsp_ready = 1'b1; force_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    check("rst_alu", {alu_op, d1, d2}, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Consumer back-pressure: response must hold for 5 cycles.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; rs1 = 32'd7; rs2 = 32'd6;
    @(posedge clk); #1; req_valid = 1'b0;
    lat = 0;
    while (lat < 20 && !rsp_valid) begin @(negedge clk); lat++; end
    check("hold_reach_resp", rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("hold%0d", c), {rsp_valid, stall, req_ready, rsp_data}, {1'b1, 1'b1, 1'b0, 32'd42});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release", {rsp_valid, req_ready}, {1'b0, 1'b1});

    // Flush 10 cycles into WAIT: drain the divider, no response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_flush_busy", alu_busy, 1);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    bad = 0; seen = 1'b0; lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
      if (!alu_busy) break;
      if (req_ready || alu_op != 3'd0) bad++;
    end
    check("drain_ready_low", bad, 0);
    check("drain_busy_fell", alu_busy, 0);
    check("drain_last_ready", req_ready, 0);
    @(negedge clk);
    check("drain_exit_ready", req_ready, 1);
    check("drain_no_rsp", {seen, rsp_valid}, 0);
    run_vec(vecs[14], 100);

    // Flush together with a request: flush wins.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; flush = 1'b1;
    #1;
    check("flush_accept_ready", req_ready, 0);
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_accept_none", {rsp_valid, alu_op, req_ready}, {1'b0, 3'd0, 1'b1});

    // Reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd50; rs2 = 32'd5;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", {req_ready, rsp_valid, alu_op, stall}, {1'b1, 1'b0, 3'd0, 1'b0});
    rst = 1'b0;
    run_vec(vecs[15], 101);

`ifdef MULDIV_WATCHDOG_EN
    // Watchdog: busy stuck high forces DRAIN after 80 WAIT cycles, then an error response.
    force_busy = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge clk); #1; req_valid = 1'b0;
    lat = 0; bad = 0;
    while (lat < 300 && !rsp_valid) begin
      @(negedge clk);
      lat++;
      if (lat == 81) check("wd_op_in_wait", alu_op, 3'd4);
      if (lat == 82) check("wd_op_drain", alu_op, 3'd0);
      if (lat == 120) force_busy = 1'b0;
    end
    check("wd_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 32'd0});
    check("wd_not_early", (lat > 120), 1);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
